multicycle_controller: RTL and testbench

//  Control FSM for the multicycle RV32I core: one shared ALU and one unified instruction/data memory.

---
 rtl/riscv_mc_pkg.sv | 72 +++++++
 rtl/ALU_Decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multicycle RV32I controller: FSM states,
// opcode constants, datapath mux encodings, ALU operation codes and trap
// causes. Imported by the controller and its ALU decoder.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    JAL,
    TRAP
  } state_e;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALUOp: what the ALU decoder should do with funct3/funct7
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ALUControl
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // States that access the unified memory and therefore wait on mem_ready.
  function automatic logic is_mem_state(input state_e s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

endpackage

// File: rtl/ALU_Decoder.sv
// ALU decoder: maps ALUOp plus instruction fields to the ALU operation.
// Ports: op5 (IR[5], separates R-type from I-type), funct3, funct7_5,
//        ALUOp from the controller state; ALUControl to the shared ALU.
module ALU_Decoder
  import riscv_mc_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      default: begin
        case (funct3)
          // funct7_5 is an immediate bit for I-type, so only R-type subtracts
          3'b000:  ALUControl = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core (shared ALU, unified memory).
// Inputs: op/funct3/funct7_5 from IR, ALU Zero, memory mem_ready handshake.
// Outputs: PC/IR/regfile/memory enables, ALU operand muxes, ALUControl,
//          ImmSrc, and trap/trap_cause (cause held until reset).
module multicycle_controller
  import riscv_mc_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]    cause_q, cause_d;

  logic       mem_state;
  logic       timeout;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
      cause_q    <= CAUSE_NONE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
    end
  end

  // The limit cycle is the one where the counter already holds WAIT_LIMIT;
  // mem_ready on that same cycle still completes the access.
  assign mem_state = is_mem_state(state_q);
  assign timeout   = mem_state && !mem_ready && (wait_cnt_q == LIMIT);

  // Counter only survives while a memory state keeps waiting; any
  // completion or state change restarts it from zero.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_state && !mem_ready && (wait_cnt_q != LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          state_d = DECODE;
        end else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BEQ;
          OP_JAL:            state_d = JAL;
          default: begin
            state_d = TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      // op[5] is the only bit separating stores from loads
      MEMADR: state_d = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD: begin
        if (mem_ready) begin
          state_d = MEMWB;
        end else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      MEMWB: state_d = FETCH;
      MEMWRITE: begin
        if (mem_ready) begin
          state_d = FETCH;
        end else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      EXECR:   state_d = ALUWB;
      EXECI:   state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BEQ:     state_d = FETCH;
      JAL:     state_d = ALUWB;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Moore output decode; only the fetch enables and branch depend on inputs
  always_comb begin
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    trap          = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
      end
      EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      ALUWB: begin
        ResultSrc     = RES_ALUOUT;
        reg_write_raw = 1'b1;
      end
      BEQ: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        branch    = 1'b1;
      end
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        pc_update = 1'b1;
      end
      TRAP:    trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

  // Gate write enables with rst_n so no pulse survives into reset, even
  // while the async reset is settling mid-cycle.
  assign PCWrite    = rst_n & (pc_update | (branch & Zero));
  assign IRWrite    = rst_n & ir_write_raw;
  assign MemWrite   = rst_n & mem_write_raw;
  assign RegWrite   = rst_n & reg_write_raw;
  assign trap_cause = cause_q;

  // Immediate format depends only on the opcode
  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  ALU_Decoder u_alu_dec (
    .op5       (op[5]),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .ALUOp     (alu_op),
    .ALUControl(ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam int WAIT_LIMIT = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, trap_cause;
  logic [2:0] ALUControl;
  logic [18:0] act;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, trap, trap_cause};

  // ---------------- reference model ----------------
  // An instruction is a recipe of micro-steps; memory steps consume
  // mem_ready and may time out, everything else takes one cycle.
  localparam int K_FETCH = 0, K_DEC = 1, K_ADR = 2, K_LOAD = 3, K_LWB = 4,
                 K_STORE = 5, K_ALUR = 6, K_ALUI = 7, K_AWB = 8, K_BR = 9,
                 K_JMP = 10;

  int         plan[$];
  bit         m_trap = 1'b0;
  logic [1:0] m_cause = 2'b00;
  int         wcnt = 0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  function automatic logic [18:0] pack(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic tr, input logic [1:0] tc);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, tr, tc};
  endfunction

  // add/sub/slt/or/and selected by funct3; subtract only for R-type with IR[30]
  function automatic logic [2:0] alu_fn(input bit rtype);
    case (funct3)
      3'b000:  return (rtype && funct7_5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [18:0] exp_out(input int k);
    case (k)
      K_FETCH: return pack(mem_ready, 1'b0, 1'b0, mem_ready, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0, 2'b00);
      K_DEC:   return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0, 2'b00);
      K_ADR:   return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0, 2'b00);
      K_LOAD:  return pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00);
      K_LWB:   return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00);
      K_STORE: return pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00);
      K_ALUR:  return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu_fn(1'b1), 1'b0, 2'b00);
      K_ALUI:  return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu_fn(1'b0), 1'b0, 2'b00);
      K_AWB:   return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00);
      K_BR:    return pack(Zero, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0, 2'b00);
      default: return pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0, 2'b00);
    endcase
  endfunction

  task automatic build_plan();
    plan.push_back(K_FETCH);
    plan.push_back(K_DEC);
    case (op)
      7'b0000011: begin plan.push_back(K_ADR); plan.push_back(K_LOAD); plan.push_back(K_LWB); end
      7'b0100011: begin plan.push_back(K_ADR); plan.push_back(K_STORE); end
      7'b0110011: begin plan.push_back(K_ALUR); plan.push_back(K_AWB); end
      7'b0010011: begin plan.push_back(K_ALUI); plan.push_back(K_AWB); end
      7'b1100011: plan.push_back(K_BR);
      7'b1101111: begin plan.push_back(K_JMP); plan.push_back(K_AWB); end
      default: ;  // illegal: decode is the last step, then trap
    endcase
  endtask

  // Compare process: called once per cycle at the falling edge, checks the
  // DUT against the model, then advances the model past the coming edge.
  task automatic model_step();
    int k;
    chk("immsrc", 32'(ImmSrc), 32'(exp_imm(op)));
    if (!rst_n) begin
      chk("reset_outputs", 32'({PCWrite, IRWrite, MemWrite, RegWrite, trap, trap_cause}), 32'(7'b0));
      plan.delete();
      m_trap = 1'b0;
      m_cause = 2'b00;
      wcnt = 0;
      return;
    end
    if (m_trap) begin
      chk("trap_outputs", 32'(act), 32'(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, m_cause)));
      return;
    end
    if (plan.size() == 0) build_plan();
    k = plan[0];
    chk($sformatf("step%0d_op%07b", k, op), 32'(act), 32'(exp_out(k)));
    if (k == K_FETCH || k == K_LOAD || k == K_STORE) begin
      if (mem_ready) begin
        void'(plan.pop_front());
        wcnt = 0;
      end else if (wcnt == WAIT_LIMIT) begin
        m_trap = 1'b1;
        m_cause = 2'b10;
        plan.delete();
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else if (k == K_DEC && plan.size() == 1) begin
      m_trap = 1'b1;
      m_cause = 2'b01;
      plan.delete();
    end else begin
      void'(plan.pop_front());
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cb(input logic mr, input logic z);
    mem_ready = mr;
    Zero = z;
    @(negedge clk);
    model_step();
  endtask

  task automatic cyc(input logic mr, input logic z);
    cb(mr, z);
    to_pos();
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o;
    funct3 = f3;
    funct7_5 = f7;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    cyc(1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  int mem_mode = 0;

  task automatic pick_instr();
    int r;
    logic [2:0] f3tab [4];
    logic [6:0] badtab [3];
    f3tab[0] = 3'b000; f3tab[1] = 3'b010; f3tab[2] = 3'b110; f3tab[3] = 3'b111;
    badtab[0] = 7'b1110011; badtab[1] = 7'b0000000; badtab[2] = 7'b0010111;
    r = $urandom_range(0, 15);
    funct3 = f3tab[$urandom_range(0, 3)];
    funct7_5 = 1'($urandom_range(0, 1));
    if (r < 3)       op = 7'b0000011;
    else if (r < 6)  op = 7'b0100011;
    else if (r < 9)  op = 7'b0110011;
    else if (r < 11) op = 7'b0010011;
    else if (r < 13) op = 7'b1100011;
    else if (r < 15) op = 7'b1101111;
    else             op = badtab[$urandom_range(0, 2)];
    r = $urandom_range(0, 19);
    mem_mode = (r == 0) ? 2 : ((r < 3) ? 1 : 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int trap_cycles;
    rst_n = 1'b0;
    set_instr(7'b0000000, 3'b000, 1'b0);
    Zero = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset: mem_ready high must not produce any enable
    cb(1'b1, 1'b0);
    chk("rst_irwrite", 32'(IRWrite), 32'(1'b0));
    chk("rst_cause", 32'(trap_cause), 32'(2'b00));
    to_pos();
    rst_n = 1'b1;

    // R-type sub: FETCH, DECODE, EXECR, ALUWB
    set_instr(7'b0110011, 3'b000, 1'b1);
    cb(1'b1, 1'b0); chk("r_fetch_irwrite", 32'(IRWrite), 32'(1'b1)); chk("r_fetch_pcwrite", 32'(PCWrite), 32'(1'b1)); to_pos();
    cb(1'b1, 1'b0); chk("r_dec_srca", 32'(ALUSrcA), 32'(2'b01)); chk("r_dec_regwrite", 32'(RegWrite), 32'(1'b0)); to_pos();
    cb(1'b1, 1'b0); chk("r_exec_aluctl", 32'(ALUControl), 32'(3'b001)); chk("r_exec_regwrite", 32'(RegWrite), 32'(1'b0)); to_pos();
    cb(1'b1, 1'b0); chk("r_wb_regwrite", 32'(RegWrite), 32'(1'b1)); to_pos();

    // lw with three wait cycles in MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0);
    cb(1'b1, 1'b0); chk("lw_fetch_irwrite", 32'(IRWrite), 32'(1'b1)); to_pos();
    cyc(1'b1, 1'b0);
    cb(1'b1, 1'b0); chk("lw_adr_srca", 32'(ALUSrcA), 32'(2'b10)); to_pos();
    for (int i = 0; i < 4; i++) begin
      cb(1'(i == 3), 1'b0);
      chk("lw_read_adrsrc", 32'(AdrSrc), 32'(1'b1));
      chk("lw_read_noen", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'(4'b0000));
      to_pos();
    end
    cb(1'b1, 1'b0); chk("lw_wb_resultsrc", 32'(ResultSrc), 32'(2'b01)); chk("lw_wb_regwrite", 32'(RegWrite), 32'(1'b1)); to_pos();

    // beq taken then not taken
    set_instr(7'b1100011, 3'b000, 1'b0);
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    cb(1'b1, 1'b1); chk("beq_taken_pcwrite", 32'(PCWrite), 32'(1'b1)); to_pos();
    cb(1'b1, 1'b0); chk("beq_back_to_fetch", 32'(IRWrite), 32'(1'b1)); to_pos();
    cyc(1'b1, 1'b0);
    cb(1'b1, 1'b0); chk("beq_nottaken_pcwrite", 32'(PCWrite), 32'(1'b0)); to_pos();

    // sw stuck for WAIT_LIMIT+1 cycles -> timeout trap
    set_instr(7'b0100011, 3'b010, 1'b0);
    cb(1'b1, 1'b0); chk("beq_return_fetch", 32'(AdrSrc), 32'(1'b0)); to_pos();
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    for (int i = 0; i <= WAIT_LIMIT; i++) begin
      cb(1'b0, 1'b0); chk("sw_wait_memwrite", 32'(MemWrite), 32'(1'b1)); to_pos();
    end
    cb(1'b0, 1'b0);
    chk("sw_timeout_trap", 32'(trap), 32'(1'b1));
    chk("sw_timeout_cause", 32'(trap_cause), 32'(2'b10));
    chk("sw_timeout_memwrite", 32'(MemWrite), 32'(1'b0));
    to_pos();
    reset_pulse();

    // sw completing on the limit cycle
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    for (int i = 0; i <= WAIT_LIMIT; i++) begin
      cb(1'(i == WAIT_LIMIT), 1'b0); chk("sw_limit_memwrite", 32'(MemWrite), 32'(1'b1)); to_pos();
    end
    cb(1'b1, 1'b0); chk("sw_limit_notrap", 32'(trap), 32'(1'b0)); chk("sw_limit_fetch", 32'(IRWrite), 32'(1'b1)); to_pos();
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);

    // illegal opcode: trap for 20 cycles, then reset
    set_instr(7'b1110011, 3'b000, 1'b0);
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cb(1'b1, 1'b0);
      chk("illegal_trap", 32'(trap), 32'(1'b1));
      chk("illegal_cause", 32'(trap_cause), 32'(2'b01));
      to_pos();
    end
    reset_pulse();

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    cb(1'b1, 1'b0); chk("post_reset_fetch", 32'(IRWrite), 32'(1'b1)); chk("post_reset_cause", 32'(trap_cause), 32'(2'b00)); to_pos();
    cyc(1'b1, 1'b0);
    cb(1'b1, 1'b0);
    chk("jal_pcwrite", 32'(PCWrite), 32'(1'b1));
    chk("jal_srca", 32'(ALUSrcA), 32'(2'b01));
    chk("jal_srcb", 32'(ALUSrcB), 32'(2'b10));
    to_pos();
    cb(1'b1, 1'b0); chk("jal_wb_regwrite", 32'(RegWrite), 32'(1'b1)); to_pos();

    // lw with reset asserted in MEMWB
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    cb(1'b1, 1'b0);
    chk("memwb_regwrite", 32'(RegWrite), 32'(1'b1));
    #1 rst_n = 1'b0;
    #1 chk("memwb_reset_regwrite", 32'(RegWrite), 32'(1'b0));
    to_pos();
    cyc(1'b1, 1'b0);
    rst_n = 1'b1;

    // randomized traffic against the model
    trap_cycles = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if (m_trap) begin
        trap_cycles++;
        if (trap_cycles > 3) begin
          rst_n = 1'b0;
          trap_cycles = 0;
        end
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
      end
      if (plan.size() == 0 && !m_trap) pick_instr();
      case (mem_mode)
        0:       mem_ready = 1'($urandom_range(0, 3) != 0);
        1:       mem_ready = 1'($urandom_range(0, 15) == 0);
        default: mem_ready = 1'b0;
      endcase
      Zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      model_step();
      to_pos();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
